// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dcache_state_e;

  localparam int DC_ADDR_W         = 32;
  localparam int DC_DATA_W         = 32;
  localparam int DC_LINES          = 64;
  localparam int DC_WORDS_PER_LINE = 4;

  localparam int DC_BYTE_W = 2;
  localparam int DC_OFF_W  = $clog2(DC_WORDS_PER_LINE);
  localparam int DC_IDX_W  = $clog2(DC_LINES);
  localparam int DC_TAG_W  = DC_ADDR_W - DC_IDX_W - DC_OFF_W - DC_BYTE_W;

  // Extract a right-justified bit field [lsb +: width] from a byte address.
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: async-read lookup, sync word write, line fill and invalidate.
module dcache_array #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 26,
  parameter int DATA_W         = 32,
  parameter int IDX_W          = $clog2(LINES),
  parameter int OFF_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_idx
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_off}];

  // Valid bits: cleared on reset, dropped when a refill starts, set on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (inv_en)  valid[inv_idx]  <= 1'b0;
      if (fill_en) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag store, written once the whole line has arrived.
  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[fill_idx] <= fill_tag;
  end

  // Data store, one word per write (store hit or refill beat).
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_off}] <= wr_data;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | lookup; read hit served combinationally, miss/write start a transaction
// REFILL | fetch line one word per beat, set tag/valid on the last beat
// WRITE  | write-through of the registered store until mem_ready
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W         = DC_ADDR_W,
  parameter int DATA_W         = DC_DATA_W,
  parameter int LINES          = DC_LINES,
  parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - DC_BYTE_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  dcache_state_e state, state_nxt;
  logic [OFF_W-1:0]  cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [OFF_W-1:0]  cpu_off;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic              rd_valid, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              arr_we, fill_en, inv_en;
  logic [OFF_W-1:0]  arr_off;
  logic [DATA_W-1:0] arr_wdata;

  assign cpu_off = OFF_W'(addr_field(32'(cpu_addr), DC_BYTE_W, OFF_W));
  assign cpu_idx = IDX_W'(addr_field(32'(cpu_addr), DC_BYTE_W + OFF_W, IDX_W));
  assign cpu_tag = TAG_W'(addr_field(32'(cpu_addr), DC_BYTE_W + OFF_W + IDX_W, TAG_W));
  assign hit     = rd_valid && (rd_tag == cpu_tag);

  dcache_array #(
    .LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_W(TAG_W), .DATA_W(DATA_W),
    .IDX_W(IDX_W), .OFF_W(OFF_W)
  ) u_array (
    .clk(clk), .rst(rst),
    .rd_idx(cpu_idx), .rd_off(cpu_off),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data),
    .wr_en(arr_we), .wr_idx(cpu_idx), .wr_off(arr_off), .wr_data(arr_wdata),
    .fill_en(fill_en), .fill_idx(cpu_idx), .fill_tag(cpu_tag),
    .inv_en(inv_en), .inv_idx(cpu_idx)
  );

  // State, beat counter and the store captured on entry to WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)                    cnt <= '0;
      else if (state == REFILL && mem_ready) cnt <= cnt + OFF_W'(1);
      if (state == IDLE && cpu_write) begin
        wr_addr <= cpu_addr;
        wr_data <= cpu_wdata;
      end
    end
  end

  // Next state, bus outputs and array write controls; everything idles during reset.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    arr_we    = 1'b0;
    arr_off   = cpu_off;
    arr_wdata = cpu_wdata;
    fill_en   = 1'b0;
    inv_en    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            stall     = 1'b1;
            arr_we    = hit;
            state_nxt = WRITE;
          end else if (cpu_read) begin
            if (hit) begin
              cpu_rdata = rd_data;
            end else begin
              stall     = 1'b1;
              inv_en    = 1'b1;
              state_nxt = REFILL;
            end
          end
        end
        REFILL: begin
          stall    = 1'b1;
          mem_read = 1'b1;
          mem_addr = {cpu_tag, cpu_idx, cnt, 2'b00};
          if (mem_ready) begin
            arr_we    = 1'b1;
            arr_off   = cnt;
            arr_wdata = mem_rdata;
            if (cnt == LAST_BEAT) begin
              fill_en   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        WRITE: begin
          mem_write = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
          stall     = !mem_ready;
          if (mem_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_fill;
  logic first_hit;

  // The lookup right after a refill hits by construction and is not a first-lookup hit.
  assign first_hit = (state == IDLE) && cpu_read && !cpu_write && hit && !after_fill && !rst;

  // Saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      after_fill <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      after_fill <= fill_en;
      if (first_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (inv_en && miss_cnt != '1)   miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
